// File: rtl/regfile_p.sv
// Multi-ported register file (2 combinational reads, 1 write) with optional
// write-through forwarding and a handshaked engine that streams every register out.
module regfile_p #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          dump_start,
    output logic          dump_busy,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_done
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [DW-1:0] regs [DEPTH];
    logic          wr_ok;

    // Register 0 is never written when hardwired, so it holds its reset value of zero.
    assign wr_ok = we && !(ZERO_REG && (wa == '0));

    // Flop-based storage: the whole array must clear on reset, which rules out block RAM.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [DW-1:0] q_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (wr_ok && (wa == AW'(gi))) begin
                    q_reg <= wd;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    assign rd1 = (ZERO_REG && (ra1 == '0))          ? '0 :
                 (BYPASS && wr_ok && (wa == ra1))   ? wd :
                                                      regs[ra1];

    assign rd2 = (ZERO_REG && (ra2 == '0))          ? '0 :
                 (BYPASS && wr_ok && (wa == ra2))   ? wd :
                                                      regs[ra2];

    state_t        state_reg;
    logic [AW-1:0] idx_reg;
    logic          valid_reg;
    logic          busy_reg;
    logic          done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    idx_reg  <= '0;
                    done_reg <= 1'b0;
                    if (dump_start) begin
                        state_reg <= RUN;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (dump_ready) begin
                        if (idx_reg == AW'(DEPTH - 1)) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + AW'(1);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_busy  = busy_reg;
    assign dump_valid = valid_reg;
    assign dump_done  = done_reg;
    assign dump_idx   = idx_reg;

    // Dump shows stored contents only; a same-cycle write becomes visible after the edge.
    assign dump_data  = (ZERO_REG && (idx_reg == '0)) ? '0 : regs[idx_reg];

endmodule

// File: tb/tb_regfile_p.sv
// Bench for regfile_p: a default instance plus a ZERO_REG=0/BYPASS=0 instance
// sharing stimulus, checked against a reference model and expectation queues.
module tb_regfile_p;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ra1 = '0, ra2 = '0, wa = '0;
    logic [DW-1:0] wd = '0;
    logic          we = 1'b0;
    logic          dump_start = 1'b0, dump_ready = 1'b0;

    logic [DW-1:0] rd1, rd2, dump_data;
    logic          dump_busy, dump_valid, dump_done;
    logic [AW-1:0] dump_idx;

    logic [DW-1:0] rd1_b, rd2_b, dump_data_b;
    logic          dump_busy_b, dump_valid_b, dump_done_b;
    logic [AW-1:0] dump_idx_b;

    regfile_p u_dut (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    regfile_p #(.DW(DW), .AW(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we(we), .wa(wa), .wd(wd), .dump_start(dump_start), .dump_busy(dump_busy_b),
        .dump_valid(dump_valid_b), .dump_ready(dump_ready), .dump_idx(dump_idx_b),
        .dump_data(dump_data_b), .dump_done(dump_done_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mdl   [DEPTH];
    logic [DW-1:0] mdl_b [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [AW+DW-1:0] beat_q [$];

    function automatic void wr_model(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (a != '0) mdl[a] = d;
        mdl_b[a] = d;
    endfunction

    function automatic void clr_model();
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i]   = '0;
            mdl_b[i] = '0;
        end
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
        wr_model(a, d);
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        rst_n = 1'b0;
        clr_model();
        repeat (2) @(negedge clk);
        // write attempted while reset is held must be dropped
        we = 1'b1; wa = 5'd3; wd = 32'h1234_5678;
        @(negedge clk);
        we = 1'b0;
        n_checks++;
        if ({dump_busy, dump_valid, dump_done} !== 3'b000 || dump_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_dump_outputs: got busy=%b valid=%b done=%b idx=%0d required all 0",
                     dump_busy, dump_valid, dump_done, dump_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < DEPTH; a++) begin
            ra1 = AW'(a);
            ra2 = AW'(DEPTH - 1 - a);
            repeat (4) exp_q.push_back('0);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (rd1 !== e) begin n_fail++; $display("FAIL reset_rd1[%0d]: got %h required %h", a, rd1, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rd2 !== e) begin n_fail++; $display("FAIL reset_rd2[%0d]: got %h required %h", DEPTH-1-a, rd2, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rd1_b !== e) begin n_fail++; $display("FAIL reset_alt_rd1[%0d]: got %h required %h", a, rd1_b, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rd2_b !== e) begin n_fail++; $display("FAIL reset_alt_rd2[%0d]: got %h required %h", DEPTH-1-a, rd2_b, e); end
        end
        $display("reset: all %0d addresses read on both ports of both instances", DEPTH);
    endtask

    task automatic test_bypass();
        logic [DW-1:0] e;
        @(negedge clk);
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd5;
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rd1 !== e) begin n_fail++; $display("FAIL bypass_rd1: got %h required %h", rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rd2 !== e) begin n_fail++; $display("FAIL bypass_rd2_same_addr: got %h required %h", rd2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rd1_b !== e) begin n_fail++; $display("FAIL nobypass_rd1_same_cycle: got %h required %h", rd1_b, e); end
        @(negedge clk);
        we = 1'b0;
        wr_model(5'd5, 32'hDEAD_BEEF);
        exp_q.push_back(mdl[5]);
        exp_q.push_back(mdl_b[5]);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rd1 !== e) begin n_fail++; $display("FAIL bypass_rd1_after: got %h required %h", rd1, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rd1_b !== e) begin n_fail++; $display("FAIL nobypass_rd1_next_cycle: got %h required %h", rd1_b, e); end
        $display("bypass: wa=5 wd=deadbeef rd1=%h alt_rd1=%h", rd1, rd1_b);
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] e;
        @(negedge clk);
        we = 1'b1; wa = '0; wd = 32'hFFFF_FFFF; ra2 = '0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rd2 !== e) begin n_fail++; $display("FAIL zero_rd2_during_write: got %h required %h", rd2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rd2_b !== e) begin n_fail++; $display("FAIL alt_rd2_during_write: got %h required %h", rd2_b, e); end
        @(negedge clk);
        we = 1'b0;
        wr_model('0, 32'hFFFF_FFFF);
        exp_q.push_back(mdl[0]);
        exp_q.push_back(mdl_b[0]);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rd2 !== e) begin n_fail++; $display("FAIL zero_rd2: got %h required %h", rd2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rd2_b !== e) begin n_fail++; $display("FAIL alt_reg0_rd2: got %h required %h", rd2_b, e); end
        $display("zero_reg: wa=0 wd=ffffffff rd2=%h alt_rd2=%h", rd2, rd2_b);
    endtask

    task automatic test_random_rw();
        logic [DW-1:0] e;
        logic [AW-1:0] a, b;
        logic [DW-1:0] d;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            a = AW'($urandom_range(0, DEPTH - 1));
            d = $urandom;
            do_write(a, d);
            b = AW'($urandom_range(0, DEPTH - 1));
            ra1 = a; ra2 = b;
            exp_q.push_back(mdl[a]);
            exp_q.push_back(mdl[b]);
            exp_q.push_back(mdl_b[a]);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (rd1 !== e) begin n_fail++; $display("FAIL rw_rd1[%0d]: got %h required %h", a, rd1, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rd2 !== e) begin n_fail++; $display("FAIL rw_rd2[%0d]: got %h required %h", b, rd2, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rd1_b !== e) begin n_fail++; $display("FAIL rw_alt_rd1[%0d]: got %h required %h", a, rd1_b, e); end
            $display("rw: wa=%0d wd=%h ra2=%0d rd1=%h rd2=%h", a, d, b, rd1, rd2);
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'(i * 32'h11));
        $display("load: reg[i] = i*0x11 for %0d registers", DEPTH);
    endtask

    task automatic test_dump(input bit toggle);
        logic [AW+DW-1:0] b;
        logic [AW-1:0]    h_idx;
        logic [DW-1:0]    h_data;
        bit               holding;
        bit               done_seen;
        int               beats;
        int               last_acc;
        holding = 0; done_seen = 0; beats = 0; last_acc = -10;
        beat_q.delete();
        for (int i = 0; i < DEPTH; i++) beat_q.push_back({AW'(i), mdl[i]});
        @(negedge clk);
        dump_start = 1'b1; dump_ready = 1'b0;
        @(negedge clk);
        dump_start = 1'b0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            dump_ready = toggle ? (c % 2 == 0) : 1'b1;
            dump_start = (c == 4);
            #1;
            if (holding) begin
                holding = 0;
                n_checks++;
                if (dump_valid !== 1'b1 || dump_idx !== h_idx || dump_data !== h_data) begin
                    n_fail++;
                    $display("FAIL dump_hold: got valid=%b idx=%0d data=%h required valid=1 idx=%0d data=%h",
                             dump_valid, dump_idx, dump_data, h_idx, h_data);
                end
            end
            if (dump_valid === 1'b1) begin
                n_checks++;
                if (dump_busy !== 1'b1) begin n_fail++; $display("FAIL dump_busy_run: got %b required 1", dump_busy); end
                if (dump_ready) begin
                    if (!toggle && dump_idx == 5'd7) begin
                        we = 1'b1; wa = 5'd7; wd = 32'hA5A5_0007;
                        #1;
                    end
                    b = (beat_q.size() > 0) ? beat_q.pop_front() : '1;
                    n_checks++;
                    if ({dump_idx, dump_data} !== b) begin
                        n_fail++;
                        $display("FAIL dump_beat: got idx=%0d data=%h required idx=%0d data=%h",
                                 dump_idx, dump_data, b[AW+DW-1:DW], b[DW-1:0]);
                    end
                    $display("beat idx=%0d data=%h", dump_idx, dump_data);
                    beats++;
                    last_acc = c;
                end else begin
                    holding = 1;
                    h_idx   = dump_idx;
                    h_data  = dump_data;
                end
            end else if (dump_done === 1'b1) begin
                done_seen = 1;
                n_checks++;
                if (beats != DEPTH || last_acc != c - 1 || dump_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dump_done_timing: got beats=%0d gap=%0d busy=%b required beats=%0d gap=1 busy=1",
                             beats, c - last_acc, dump_busy, DEPTH);
                end
            end else begin
                n_checks++; n_fail++;
                $display("FAIL dump_stall: got valid=0 done=0 at cycle %0d required valid or done", c);
            end
            @(negedge clk);
            if (we) begin
                wr_model(wa, wd);
                we = 1'b0;
            end
        end
        dump_start = 1'b0;
        n_checks++;
        if (!done_seen) begin n_fail++; $display("FAIL dump_timeout: got no dump_done required done within 200 cycles"); end
        #1;
        n_checks++;
        if ({dump_done, dump_busy, dump_valid} !== 3'b000 || dump_idx !== '0) begin
            n_fail++;
            $display("FAIL dump_after_done: got done=%b busy=%b valid=%b idx=%0d required 0 0 0 0",
                     dump_done, dump_busy, dump_valid, dump_idx);
        end
        n_checks++;
        if (beat_q.size() != 0) begin n_fail++; $display("FAIL dump_leftover: got %0d beats pending required 0", beat_q.size()); end
        $display("dump toggle=%0b: %0d beats, done seen=%0b", toggle, beats, done_seen);
    endtask

    task automatic test_dump_reset();
        logic [AW+DW-1:0] b;
        bit               aborted;
        aborted = 0;
        beat_q.delete();
        for (int i = 0; i < DEPTH; i++) beat_q.push_back({AW'(i), mdl[i]});
        @(negedge clk);
        dump_start = 1'b1; dump_ready = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int c = 0; c < 40 && !aborted; c++) begin
            #1;
            b = (beat_q.size() > 0) ? beat_q.pop_front() : '1;
            n_checks++;
            if (dump_valid !== 1'b1 || {dump_idx, dump_data} !== b) begin
                n_fail++;
                $display("FAIL abort_beat: got valid=%b idx=%0d data=%h required valid=1 idx=%0d data=%h",
                         dump_valid, dump_idx, dump_data, b[AW+DW-1:DW], b[DW-1:0]);
            end
            if (c == 10) begin
                rst_n = 1'b0;
                #1;
                aborted = 1;
                clr_model();
                beat_q.delete();
                ra1 = 5'd7;
                n_checks++;
                if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_idx !== '0 || rd1 !== '0) begin
                    n_fail++;
                    $display("FAIL abort_async_clear: got valid=%b busy=%b done=%b idx=%0d rd1=%h required all 0",
                             dump_valid, dump_busy, dump_done, dump_idx, rd1);
                end
                $display("abort: reset asserted at beat idx=10");
            end else begin
                @(negedge clk);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done: got done=%b valid=%b required 0 0", dump_done, dump_valid);
            end
        end
        rst_n = 1'b1;
        dump_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion required end of test");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_random_rw();
        test_load();
        test_dump(1'b0);
        test_load();
        test_dump(1'b1);
        test_dump_reset();
        test_dump(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_p.md
REGFILE_P -- requirements
Module: regfile_p

Interface
REQ-001 SHALL provide parameter DW, default 32, register data width in bits.
REQ-002 SHALL provide parameter AW, default 5, address width; DEPTH = 2**AW registers.
REQ-003 SHALL provide parameter ZERO_REG, default 1, hardwires register 0 to zero when 1.
REQ-004 SHALL provide parameter BYPASS, default 1, enables write-to-read forwarding when 1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; no other clock or reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 ra1, ra2  input  AW  read addresses, ports 1 and 2.
REQ-009 rd1, rd2  output  DW  read data, ports 1 and 2, combinational.
REQ-010 we  input  1  write enable.
REQ-011 wa  input  AW  write address.
REQ-012 wd  input  DW  write data.
REQ-013 dump_start  input  1  single-cycle request to stream all registers out.
REQ-014 dump_busy  output  1  high while the dump engine is not IDLE.
REQ-015 dump_valid  output  1  dump_idx/dump_data are valid.
REQ-016 dump_ready  input  1  consumer accepts the current dump beat.
REQ-017 dump_idx  output  AW  index of the register being dumped.
REQ-018 dump_data  output  DW  stored contents of register dump_idx.
REQ-019 dump_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-020 Write: at rising clk with we=1, reg[wa] <= wd, except no write when ZERO_REG=1 and wa=0.
REQ-021 Read: rdN = reg[raN] combinationally; rdN = 0 when ZERO_REG=1 and raN=0.
REQ-022 Bypass: BYPASS=1, we=1, wa=raN, write permitted per REQ-020 -> rdN = wd in the same cycle.
REQ-023 BYPASS=0 -> rdN shows the old value until the cycle after the write edge.
REQ-024 Both read ports SHALL be independent; ra1=ra2 returns identical data.
REQ-025 Dump FSM states: IDLE, RUN, DONE.
REQ-026 IDLE: dump_start=1 at clk -> RUN with dump_idx=0; otherwise stay IDLE.
REQ-027 RUN: dump_valid=1; dump_data = stored reg[dump_idx] (no bypass; 0 for index 0 when ZERO_REG=1).
REQ-028 RUN: dump_valid & dump_ready at clk -> dump_idx+1, or DONE if dump_idx = DEPTH-1; no ready -> hold idx and data stable except through register writes.
REQ-029 DONE: dump_done=1 for exactly one cycle, then IDLE with dump_idx=0.
REQ-030 dump_start while RUN or DONE SHALL be ignored.
REQ-031 Write to reg[dump_idx] during an accepted beat: the beat carries the pre-edge value.
REQ-032 Register writes and reads SHALL proceed unaffected during a dump.
REQ-033 dump_idx SHALL never wrap; DEPTH beats exactly per dump.

Reset
REQ-034 rst_n=0 SHALL immediately clear all registers to 0, FSM to IDLE, dump_idx=0, dump_valid=0, dump_busy=0, dump_done=0.
REQ-035 Reset mid-dump SHALL abort the dump with no dump_done pulse; a new dump_start after release restarts at index 0.
REQ-036 Writes are blocked while rst_n=0.

Verification
REQ-037 Reset, then read all 32 addresses on both ports -> every rd = 0x00000000.
REQ-038 we=1, wa=5, wd=0xDEADBEEF, ra1=5 same cycle -> rd1=0xDEADBEEF with BYPASS=1; rd1=0 that cycle, 0xDEADBEEF next cycle with BYPASS=0.
REQ-039 we=1, wa=0, wd=0xFFFFFFFF, then ra2=0 -> rd2=0 (ZERO_REG=1); 0xFFFFFFFF with ZERO_REG=0.
REQ-040 Load reg[i]=i*0x11, pulse dump_start, dump_ready=1 -> 32 beats idx 0..31, data i*0x11 (idx 0 -> 0), dump_done one cycle after beat 31, busy low after.
REQ-041 Dump with dump_ready toggled 1/0 each cycle -> idx and data held on ready=0, still 32 beats, no skips or repeats.
REQ-042 Assert rst_n=0 at beat 10 of a dump -> outputs cleared asynchronously, no dump_done; restart dump -> begins at idx 0 with all data 0.
